// File: rtl/clock_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_monitor_pkg
//  Purpose  : Shared types and constants for the clock monitor: state
//             encoding (2-bit) and default counter width / loss timeout.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package clock_monitor_pkg;

    localparam int unsigned c_CNT_W_DEFAULT   = 32;
    localparam int unsigned c_TIMEOUT_DEFAULT = 200000000;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_MEASURE = 2'd1;
    localparam logic [1:0] c_ST_LOST    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = c_ST_IDLE,
        ST_MEASURE = c_ST_MEASURE,
        ST_LOST    = c_ST_LOST
    } state_t;

endpackage : clock_monitor_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Generic two-flop synchroniser for bringing asynchronous level
//             signals into the clk domain. Synchronous active-low reset.
//  Ports    : clk   - destination clock
//             rst_n - synchronous reset, active-low (flops cleared to 0)
//             i_d   - asynchronous input, WIDTH bits
//             o_q   - synchronised output, WIDTH bits (2 cycles latency)
//  Revision : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // r_meta may go metastable; only r_sync is consumed downstream.
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/clock_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : clock_monitor
//  Purpose  : Synchronises a slow clock into the clk domain, emits one-cycle
//             rise/fall pulses, measures period and high time in clk cycles
//             and flags loss of the slow clock.
//  Ports    : clk        - fast system clock (rising edge)
//             rst_n      - synchronous reset, active-low
//             clk_slow   - monitored slow clock, asynchronous to clk
//             rise_pulse - one-cycle pulse per detected rising edge
//             fall_pulse - one-cycle pulse per detected falling edge
//             period     - last rise-to-rise interval [CNT_W]
//             high_time  - last rise-to-fall interval [CNT_W]
//             meas_vld   - one-cycle pulse when period/high_time update
//             clk_lost   - high while the slow clock is considered lost
//  Config   : CLOCK_MONITOR_DUTY_EN - when defined, high-time capture is
//             built; otherwise high_time is tied to 0.
//  Revision : 1.0  initial release
// ============================================================================
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int unsigned CNT_W   = c_CNT_W_DEFAULT,
    parameter int unsigned TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_slow,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_vld,
    output logic             clk_lost
);

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    // ------------------------------------------------------------------
    // Synchroniser and edge detection
    // ------------------------------------------------------------------
    logic       w_s1;
    logic       r_s2;
    logic [1:0] r_warm;
    logic       w_warm_done;
    logic       w_rise;
    logic       w_fall;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (clk_slow),
        .o_q   (w_s1)
    );

    // Edges are ignored until s0, s1 and s2 all hold real samples taken
    // after reset. Without this, a slow clock that is already high at
    // reset release would look like a rising edge against the cleared
    // history flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2   <= 1'b0;
            r_warm <= 2'd0;
        end else begin
            r_s2 <= w_s1;
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end
        end
    end

    assign w_warm_done = (r_warm == 2'd3);
    assign w_rise      = w_warm_done &  w_s1 & ~r_s2;
    assign w_fall      = w_warm_done & ~w_s1 &  r_s2;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_timeout;
    logic             w_meas_load;

    assign w_timeout = (r_cnt >= c_TIMEOUT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A rise event always takes priority over the timeout check, so a
    // clock whose period equals TIMEOUT is still measured, never lost.
    always_comb begin
        w_state_nxt = r_state;
        w_meas_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_MEASURE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_LOST;
                end
            end
            ST_MEASURE: begin
                if (w_rise) begin
                    w_meas_load = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt = ST_LOST;
                end
            end
            ST_LOST: begin
                if (w_rise) begin
                    w_state_nxt = ST_MEASURE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Interval counter and registered outputs
    // ------------------------------------------------------------------
    logic             r_rise_pulse;
    logic             r_fall_pulse;
    logic             r_meas_vld;
    logic [CNT_W-1:0] r_period;

    // The counter loads 1 on a rise so that its value at the next rise
    // equals the number of clk cycles between the two rise events.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_rise_pulse <= 1'b0;
            r_fall_pulse <= 1'b0;
            r_meas_vld   <= 1'b0;
            r_period     <= '0;
        end else begin
            r_rise_pulse <= w_rise;
            r_fall_pulse <= w_fall;
            r_meas_vld   <= w_meas_load;
            if (w_rise) begin
                r_cnt <= c_ONE;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + c_ONE;
            end
            if (w_meas_load) begin
                r_period <= r_cnt;
            end
        end
    end

    assign rise_pulse = r_rise_pulse;
    assign fall_pulse = r_fall_pulse;
    assign meas_vld   = r_meas_vld;
    assign period     = r_period;
    assign clk_lost   = (r_state == ST_LOST);

    // ------------------------------------------------------------------
    // Optional high-time measurement
    // ------------------------------------------------------------------
`ifdef CLOCK_MONITOR_DUTY_EN
    logic [CNT_W-1:0] r_hi_cnt;
    logic [CNT_W-1:0] r_high_time;

    // Falls seen outside MEASURE belong to an interval that will not be
    // reported, so they do not touch the capture register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi_cnt    <= '0;
            r_high_time <= '0;
        end else begin
            if (w_fall && (r_state == ST_MEASURE)) begin
                r_hi_cnt <= r_cnt;
            end
            if (w_meas_load) begin
                r_high_time <= r_hi_cnt;
            end
        end
    end

    assign high_time = r_high_time;
`else
    assign high_time = '0;
`endif

endmodule : clock_monitor
`default_nettype wire
